// File: rtl/fmm_matrix_buf_ctrl.sv
// fmm_matrix_buf_ctrl: arbitrates one writer and one reader onto a single-port matrix BRAM, with optional zero-fill.
// Latency: BRAM port driven 1 cycle after a grant; read data returned 2 cycles after the read handshake.
// Backpressure: ready is the combinational grant; zero-fill, drain and idle hold both requesters off.
module fmm_matrix_buf_ctrl #(
  parameter int ROWS = 320,
  parameter int COLS = 320,
  parameter int AW   = 17,
  parameter int DW   = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  // block-level handshake
  input  logic          ap_start,
  input  logic          clear_en,
  output logic          ap_ready,
  output logic          ap_done,
  output logic          ap_idle,
  input  logic          done_req,
  // write requester
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [8:0]    wr_row,
  input  logic [8:0]    wr_col,
  input  logic [DW-1:0] wr_data,
  // read requester
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [8:0]    rd_row,
  input  logic [8:0]    rd_col,
  output logic          rd_rvalid,
  output logic [DW-1:0] rd_rdata,
  // sticky coordinate error
  output logic          err_oob,
  // single-port BRAM, 1-cycle read latency
  output logic [AW-1:0] M_e_address0,
  output logic          M_e_ce0,
  output logic          M_e_we0,
  output logic [DW-1:0] M_e_d0,
  input  logic [DW-1:0] M_e_q0
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SERVE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Coordinate limits narrowed to the 9-bit coordinate width so compares stay width-matched.
  localparam logic [8:0] ROW_LIM  = 9'(ROWS);
  localparam logic [8:0] COL_LIM  = 9'(COLS);
  localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);
  localparam logic [8:0] COL_LAST = 9'(COLS - 1);

  state_t     state;
  logic [8:0] row_cnt;     // zero-fill row (outer loop)
  logic [8:0] col_cnt;     // zero-fill column (inner loop)
  logic       drain_cnt;   // counts the two drain cycles
  logic       prio_wr;     // 1: writer wins the next contended cycle

  logic       start_acc;
  logic       serve_open;
  logic       contended;
  logic       wr_gnt;
  logic       rd_gnt;
  logic       wr_oob;
  logic       rd_oob;

  // read-return pipeline: stage 1 aligns with the BRAM request, stage 2 with M_e_q0
  logic       rd_pend1;
  logic       rd_oob1;
  logic       rd_zero2;

  // Row-major linear address r*320 + c built from shifts; matches a 320-column matrix.
  function automatic logic [AW-1:0] rc_addr(input logic [8:0] r, input logic [8:0] c);
    logic [AW-1:0] rr;
    logic [AW-1:0] cc;
    rr = AW'(r);
    cc = AW'(c);
    return (rr << 8) + (rr << 6) + cc;
  endfunction

  // Grant arbitration and start acceptance; everything here is same-cycle combinational.
  always_comb begin
    start_acc  = (state == S_IDLE) && ap_start;
    serve_open = (state == S_SERVE) && !done_req;
    contended  = serve_open && wr_valid && rd_valid;
    wr_gnt     = serve_open && wr_valid && (!rd_valid || prio_wr);
    rd_gnt     = serve_open && rd_valid && !wr_gnt;
    wr_oob     = (wr_row >= ROW_LIM) || (wr_col >= COL_LIM);
    rd_oob     = (rd_row >= ROW_LIM) || (rd_col >= COL_LIM);
  end

  assign ap_ready = start_acc;
  assign ap_idle  = (state == S_IDLE);
  assign wr_ready = wr_gnt;
  assign rd_ready = rd_gnt;

  // Out-of-range reads still return a response, forced to zero rather than stale BRAM output.
  assign rd_rdata = (rd_rvalid && !rd_zero2) ? M_e_q0 : '0;

  // Control FSM: session start, zero-fill sweep, serving with rotating priority, drain and done pulse.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      row_cnt   <= '0;
      col_cnt   <= '0;
      drain_cnt <= 1'b0;
      prio_wr   <= 1'b1;
      ap_done   <= 1'b0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            row_cnt <= '0;
            col_cnt <= '0;
            // priority restarts with the writer on every serving session
            prio_wr <= 1'b1;
            state   <= clear_en ? S_CLEAR : S_SERVE;
          end
        end
        S_CLEAR: begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= S_SERVE;
            end else begin
              row_cnt <= row_cnt + 9'd1;
            end
          end else begin
            col_cnt <= col_cnt + 9'd1;
          end
        end
        S_SERVE: begin
          if (done_req) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end else if (contended) begin
            // only a contested grant hands priority to the loser
            prio_wr <= !prio_wr;
          end
        end
        S_DRAIN: begin
          // two cycles cover the longest in-flight read before reporting done
          if (drain_cnt) begin
            ap_done <= 1'b1;
            state   <= S_IDLE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // BRAM port registers, read-return pipeline and sticky error flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      M_e_address0 <= '0;
      M_e_ce0      <= 1'b0;
      M_e_we0      <= 1'b0;
      M_e_d0       <= '0;
      rd_pend1     <= 1'b0;
      rd_oob1      <= 1'b0;
      rd_rvalid    <= 1'b0;
      rd_zero2     <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      M_e_ce0 <= 1'b0;
      M_e_we0 <= 1'b0;
      if (state == S_CLEAR) begin
        M_e_ce0      <= 1'b1;
        M_e_we0      <= 1'b1;
        M_e_d0       <= '0;
        M_e_address0 <= rc_addr(row_cnt, col_cnt);
      end else if (wr_gnt && !wr_oob) begin
        M_e_ce0      <= 1'b1;
        M_e_we0      <= 1'b1;
        M_e_d0       <= wr_data;
        M_e_address0 <= rc_addr(wr_row, wr_col);
      end else if (rd_gnt && !rd_oob) begin
        M_e_ce0      <= 1'b1;
        M_e_address0 <= rc_addr(rd_row, rd_col);
      end

      rd_pend1  <= rd_gnt;
      rd_oob1   <= rd_gnt && rd_oob;
      rd_rvalid <= rd_pend1;
      rd_zero2  <= rd_oob1;

      if (start_acc) begin
        err_oob <= 1'b0;
      end else if ((wr_gnt && wr_oob) || (rd_gnt && rd_oob)) begin
        err_oob <= 1'b1;
      end
    end
  end

  // Arbitration never grants both requesters in one cycle.
  a_single_grant : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    !(wr_ready && rd_ready));

  // Requesters are only ever accepted while serving.
  a_ready_only_serve : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (state != S_SERVE) |-> !(wr_ready || rd_ready));

endmodule

// File: tb/tb_fmm_matrix_buf_ctrl.sv
// tb_fmm_matrix_buf_ctrl: scoreboard bench for fmm_matrix_buf_ctrl with a behavioural BRAM and reference model.
// Runs a 16-row x 320-column matrix so a full zero-fill stays short while keeping the 320-column address layout.
// Stimulus pushes expected BRAM ops / read responses with their due cycle; monitors pop and compare.
module tb_fmm_matrix_buf_ctrl;
  localparam int TB_ROWS = 16;
  localparam int TB_COLS = 320;
  localparam int AW      = 17;
  localparam int DW      = 32;

  logic          ap_clk;
  logic          ap_rst_n;
  logic          ap_start, clear_en, ap_ready, ap_done, ap_idle, done_req;
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid, err_oob;
  logic [8:0]    wr_row, wr_col, rd_row, rd_col;
  logic [DW-1:0] wr_data, rd_rdata, M_e_d0, M_e_q0;
  logic [AW-1:0] M_e_address0;
  logic          M_e_ce0, M_e_we0;

  fmm_matrix_buf_ctrl #(.ROWS(TB_ROWS), .COLS(TB_COLS), .AW(AW), .DW(DW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .ap_start(ap_start), .clear_en(clear_en), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_idle(ap_idle), .done_req(done_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .err_oob(err_oob),
    .M_e_address0(M_e_address0), .M_e_ce0(M_e_ce0), .M_e_we0(M_e_we0),
    .M_e_d0(M_e_d0), .M_e_q0(M_e_q0)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  // behavioural single-port BRAM, 1-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge ap_clk) begin
    if (M_e_ce0) begin
      if (M_e_we0) mem[M_e_address0] <= M_e_d0;
      else         M_e_q0 <= mem[M_e_address0];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { bit we; int addr; logic [31:0] data; int at; } bop_t;
  typedef struct { logic [31:0] data; int at; } rsp_t;
  bop_t bram_q[$];
  rsp_t rd_q[$];
  logic [31:0] ref_mem [int];
  bit m_prio_w = 1'b1;
  bit m_err    = 1'b0;
  bit last_w, last_r;

  // BRAM port monitor: every enabled cycle must match the next expected op, on its due cycle
  always @(negedge ap_clk) begin : bram_mon
    bop_t e;
    if (ap_rst_n && M_e_ce0) begin
      if (bram_q.size() == 0) chk("bram_extra_op", 64'(M_e_ce0), 64'(0));
      else begin
        e = bram_q.pop_front();
        chk("bram_we", 64'(M_e_we0), 64'(e.we));
        chk("bram_addr", 64'(M_e_address0), 64'(e.addr));
        if (e.we) chk("bram_d0", 64'(M_e_d0), 64'(e.data));
        chk("bram_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // read response monitor
  always @(negedge ap_clk) begin : rd_mon
    rsp_t r;
    if (rd_rvalid) begin
      if (rd_q.size() == 0) chk("rd_extra_rvalid", 64'(rd_rvalid), 64'(0));
      else begin
        r = rd_q.pop_front();
        chk("rd_rdata", 64'(rd_rdata), 64'(r.data));
        chk("rd_latency", 64'(cyc), 64'(r.at));
      end
    end
  end

  // one SERVE cycle: drive requests, check grants against the priority rule, queue expectations
  task automatic serve(input bit wv, input int wr, input int wc, input logic [31:0] wd,
                       input bit rv, input int rr, input int rc, input bit dq, input bit st);
    bit ew, er;
    int a;
    @(posedge ap_clk); #1;
    wr_valid = wv; wr_row = 9'(wr); wr_col = 9'(wc); wr_data = wd;
    rd_valid = rv; rd_row = 9'(rr); rd_col = 9'(rc);
    done_req = dq; ap_start = st; clear_en = 1'b0;
    @(negedge ap_clk);
    chk("err_oob", 64'(err_oob), 64'(m_err));
    chk("ap_idle_serve", 64'(ap_idle), 64'(0));
    ew = wv && !dq && (!rv || m_prio_w);
    er = rv && !dq && (!wv || !m_prio_w);
    chk("wr_ready", 64'(wr_ready), 64'(ew));
    chk("rd_ready", 64'(rd_ready), 64'(er));
    last_w = wr_ready; last_r = rd_ready;
    if (st) chk("ap_ready_ignored", 64'(ap_ready), 64'(0));
    if (wv && rv && !dq) m_prio_w = !m_prio_w;
    if (ew) begin
      if (wr < TB_ROWS && wc < TB_COLS) begin
        a = wr * TB_COLS + wc;
        ref_mem[a] = wd;
        bram_q.push_back('{1'b1, a, wd, cyc + 1});
      end else m_err = 1'b1;
    end
    if (er) begin
      if (rr < TB_ROWS && rc < TB_COLS) begin
        a = rr * TB_COLS + rc;
        bram_q.push_back('{1'b0, a, 32'h0, cyc + 1});
        rd_q.push_back('{ref_mem.exists(a) ? ref_mem[a] : 32'h0, cyc + 2});
      end else begin
        m_err = 1'b1;
        rd_q.push_back('{32'h0, cyc + 2});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) serve(1'b0, 0, 0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_start(input bit ce);
    int a0;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; clear_en = ce;
    @(negedge ap_clk);
    chk("ap_ready_start", 64'(ap_ready), 64'(1));
    chk("ap_idle_start", 64'(ap_idle), 64'(1));
    a0 = cyc;
    if (ce) begin
      ref_mem.delete();
      for (int i = 0; i < TB_ROWS * TB_COLS; i++) bram_q.push_back('{1'b1, i, 32'h0, a0 + 2 + i});
    end
    m_prio_w = 1'b1;
    m_err    = 1'b0;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; clear_en = 1'b0;
    @(negedge ap_clk);
    chk("err_oob_cleared", 64'(err_oob), 64'(0));
    chk("ap_ready_once", 64'(ap_ready), 64'(0));
  endtask

  // watch the zero-fill sweep; requests and done_req are held high early on and must be ignored
  task automatic wait_clear(input int n);
    int seen, cycles;
    bit bad;
    seen = 0; cycles = 0; bad = 1'b0;
    wr_valid = 1'b1; rd_valid = 1'b1; done_req = 1'b1;
    wr_row = 9'd0; wr_col = 9'd0; rd_row = 9'd0; rd_col = 9'd0;
    while (seen < n && cycles < n + 200) begin
      @(negedge ap_clk);
      cycles++;
      if (wr_ready || rd_ready) bad = 1'b1;
      if (M_e_ce0 && M_e_we0) seen++;
      if (cycles == 40) begin wr_valid = 1'b0; rd_valid = 1'b0; done_req = 1'b0; end
    end
    chk("clear_ready_low", 64'(bad), 64'(0));
    chk("clear_count", 64'(seen), 64'(n));
    chk("clear_consecutive", 64'(cycles), 64'(n));
  endtask

  // done_req coincident with a read, then drain, done pulse and idle
  task automatic end_session();
    serve(1'b0, 0, 0, 32'h0, 1'b1, 1, 1, 1'b1, 1'b0);
    @(posedge ap_clk); #1;
    wr_valid = 1'b1; rd_valid = 1'b1; done_req = 1'b0;
    wr_row = 9'd0; wr_col = 9'd0; rd_row = 9'd0; rd_col = 9'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge ap_clk);
      chk("ap_done", 64'(ap_done), 64'(k == 3));
      chk("ap_idle_after_drain", 64'(ap_idle), 64'(k >= 3));
      chk("drain_wr_ready", 64'(wr_ready), 64'(0));
      chk("drain_rd_ready", 64'(rd_ready), 64'(0));
    end
    chk("err_oob_idle", 64'(err_oob), 64'(m_err));
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] wseq, rseq;
    ap_rst_n = 1'b0; ap_start = 1'b0; clear_en = 1'b0; done_req = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0; wr_row = '0; wr_col = '0; rd_row = '0; rd_col = '0;
    wr_data = '0;
    #3;
    chk("rst_ap_idle", 64'(ap_idle), 64'(1));
    chk("rst_ap_ready", 64'(ap_ready), 64'(0));
    chk("rst_ap_done", 64'(ap_done), 64'(0));
    chk("rst_ready", 64'({wr_ready, rd_ready}), 64'(0));
    chk("rst_rvalid", 64'(rd_rvalid), 64'(0));
    chk("rst_err_oob", 64'(err_oob), 64'(0));
    chk("rst_ce_we", 64'({M_e_ce0, M_e_we0}), 64'(0));
    chk("rst_addr", 64'(M_e_address0), 64'(0));
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // full zero-fill, then serve
    do_start(1'b1);
    wait_clear(TB_ROWS * TB_COLS);

    // write then read the same cell on the next cycle
    serve(1'b1, 5, 7, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 1'b1, 5, 7, 1'b0, 1'b0);
    idle(3);

    // continuous contention alternates starting with the writer
    wseq = '0; rseq = '0;
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, i, 10 + i, 32'hA000_0000 + i, 1'b1, i, 20 + i, 1'b0, 1'b0);
      wseq = {wseq[2:0], last_w};
      rseq = {rseq[2:0], last_r};
    end
    chk("contend_w_seq", 64'(wseq), 64'(4'b1010));
    chk("contend_r_seq", 64'(rseq), 64'(4'b0101));
    idle(3);

    // out-of-range and boundary coordinates
    serve(1'b0, 0, 0, 32'h0, 1'b1, 320, 0, 1'b0, 1'b0);
    idle(2);
    chk("err_oob_set", 64'(err_oob), 64'(1));
    serve(1'b1, 0, 320, 32'h1111_2222, 1'b0, 0, 0, 1'b0, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 1'b1, TB_ROWS, 0, 1'b0, 1'b0);
    serve(1'b1, TB_ROWS - 1, TB_COLS - 1, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 1'b1, TB_ROWS - 1, TB_COLS - 1, 1'b0, 1'b0);

    // ap_start while serving is ignored
    serve(1'b0, 0, 0, 32'h0, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(3);

    // randomized traffic on a small address window with occasional out-of-range coordinates
    for (int i = 0; i < 400; i++) begin
      int wr, wc, rr, rc;
      bit wv, rv;
      wv = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TB_ROWS, 511)) : int'($urandom_range(0, 3));
      wc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TB_COLS, 511)) : int'($urandom_range(0, 3));
      rr = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TB_ROWS, 511)) : int'($urandom_range(0, 3));
      rc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TB_COLS, 511)) : int'($urandom_range(0, 3));
      serve(wv, wr, wc, $urandom, rv, rr, rc, 1'b0, 1'b0);
    end
    idle(3);
    chk("err_oob_sticky", 64'(err_oob), 64'(1));
    end_session();

    // restart without zero-fill: memory persists, priority back to the writer
    do_start(1'b0);
    serve(1'b1, 2, 2, 32'h1234_5678, 1'b1, 5, 7, 1'b0, 1'b0);
    chk("prio_reset_w", 64'(last_w), 64'(1));
    serve(1'b0, 0, 0, 32'h0, 1'b1, 5, 7, 1'b0, 1'b0);
    serve(1'b0, 0, 0, 32'h0, 1'b1, 2, 2, 1'b0, 1'b0);
    idle(3);
    end_session();

    // reset in the middle of a zero-fill aborts it; a restart sweeps again from address 0
    do_start(1'b1);
    wait_clear(5000);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst_ce0", 64'(M_e_ce0), 64'(0));
    chk("midrst_we0", 64'(M_e_we0), 64'(0));
    chk("midrst_ap_idle", 64'(ap_idle), 64'(1));
    chk("midrst_rvalid", 64'(rd_rvalid), 64'(0));
    bram_q.delete();
    rd_q.delete();
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    do_start(1'b1);
    wait_clear(TB_ROWS * TB_COLS);
    serve(1'b0, 0, 0, 32'h0, 1'b1, 5, 7, 1'b0, 1'b0);
    idle(3);

    chk("bram_q_drained", 64'(bram_q.size()), 64'(0));
    chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
